// File: rtl/snn_img_sender.sv
// Host-side image sender: packs a 784-pixel 1bpp image into bytes, streams them to uart_tx and
// waits for the ASCII digit reply. Optional reply timeout enabled by SNN_HOST_TIMEOUT_EN.
module snn_img_sender #(
  parameter int NUM_BYTES      = 98,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  output logic [9:0] img_addr,
  input  logic       img_q,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_rdy,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit,
  output logic       resp_err,
  output logic       timeout
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, TXW, RESP} state_t;

  localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

  state_t     state, state_nx;
  logic [6:0] bcnt;
  logic [3:0] pcnt;
  logic [7:0] shreg;
  logic       txw_hold;
  logic       last_byte;
  logic       tmo_hit;

  assign last_byte = (bcnt == LAST_BYTE);
  assign busy      = (state != IDLE);
  assign img_addr  = {bcnt, 3'b000} + {7'd0, pcnt[2:0]};

`ifdef SNN_HOST_TIMEOUT_EN
  logic [22:0] tcnt;
  assign tmo_hit = (state == RESP) && (tcnt == 23'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != RESP) tcnt <= '0;
    else                      tcnt <= tcnt + 23'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    case (state)
      IDLE:  if (go) state_nx = FETCH;
      FETCH: if (pcnt == 4'd8) state_nx = SEND;
      SEND:  if (tx_rdy) begin
        tx_start = 1'b1;
        state_nx = TXW;
      end
      // First TXW cycle ignores tx_rdy: uart_tx only drops it the cycle after tx_start.
      TXW:   if (!txw_hold && tx_rdy) state_nx = last_byte ? RESP : FETCH;
      RESP:  if (rx_rdy || tmo_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt     <= '0;
      pcnt     <= '0;
      shreg    <= '0;
      tx_data  <= '0;
      txw_hold <= 1'b0;
      done     <= 1'b0;
      digit    <= '0;
      resp_err <= 1'b0;
`ifdef SNN_HOST_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          bcnt <= '0;
          pcnt <= '0;
        end
        FETCH: begin
          // img_q lags img_addr by one cycle, so shifting starts at pcnt=1.
          if (pcnt != 4'd8) pcnt <= pcnt + 4'd1;
          if (pcnt != 4'd0) shreg <= {img_q, shreg[7:1]};
          if (pcnt == 4'd8) tx_data <= {img_q, shreg[7:1]};
        end
        SEND: txw_hold <= 1'b1;
        TXW: begin
          txw_hold <= 1'b0;
          if (!txw_hold && tx_rdy && !last_byte) begin
            bcnt <= bcnt + 7'd1;
            pcnt <= '0;
          end
        end
        RESP: begin
          if (rx_rdy) begin
            digit    <= rx_data[3:0];
            resp_err <= (rx_data[7:4] != 4'h3) || (rx_data[3:0] > 4'd9);
            done     <= 1'b1;
`ifdef SNN_HOST_TIMEOUT_EN
            timeout  <= 1'b0;
          end else if (tmo_hit) begin
            timeout  <= 1'b1;
            digit    <= 4'hF;
            resp_err <= 1'b0;
            done     <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_img_sender.sv
// Bench for snn_img_sender: image memory, uart_tx busy model and a packing/reply reference model.
module tb_snn_img_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [9:0] img_addr;
  logic       img_q = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_rdy = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       busy, done, resp_err, timeout;
  logic [3:0] digit;

  snn_img_sender #(.NUM_BYTES(98), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .go(go), .img_addr(img_addr), .img_q(img_q),
    .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .rx_rdy(rx_rdy), .rx_data(rx_data), .busy(busy), .done(done),
    .digit(digit), .resp_err(resp_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  bit pix [0:783];
  int busy_len = 10;
  bit rand_len = 1'b0;
  int tcnt = 0;

  // Synchronous image memory.
  always @(posedge clk) img_q <= pix[img_addr];

  // uart_tx: busy for a number of cycles after each start request.
  always @(posedge clk) begin
    if (tx_start) begin
      tx_rdy <= 1'b0;
      tcnt   <= rand_len ? int'($urandom_range(1, 15)) : busy_len;
    end else if (tcnt > 0) begin
      tcnt <= tcnt - 1;
      if (tcnt == 1) tx_rdy <= 1'b1;
    end
  end

  logic [7:0] sent_q[$];
  int start_q[$];
  int done_q[$];
  int cyc = 0;
  int bad_start = 0;
  int max_addr = 0;

  always @(negedge clk) begin
    cyc++;
    if (int'(img_addr) > max_addr) max_addr = int'(img_addr);
    if (tx_start) begin
      if (!tx_rdy) bad_start++;
      sent_q.push_back(tx_data);
      start_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] exp_byte(input int b);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = pix[8*b + i];
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_img_addr"}, img_addr, 0);
    check({tag, "_digit"}, digit, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // One transaction; returns early after a mid-send reset when rst50 is set.
  task automatic run_txn(input string tag, input logic [7:0] reply, input bit do_reply,
                         input bit extra_rx, input bit extra_go, input bit rst50);
    int base = sent_q.size();
    int sbase = start_q.size();
    int d0 = done_q.size();
    int k = 0;
    int n;
    int min_gap = 1000;
    bit went = 1'b0;
    bit exp_err;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check({tag, "_busy_after_go"}, busy, 1);
    check({tag, "_addr_after_go"}, img_addr, 0);
    while (sent_q.size() - base < 98 && k < 5000) begin
      if (extra_rx && $urandom_range(0, 7) == 0) begin
        rx_rdy = 1'b1;
        rx_data = 8'($urandom);
      end else rx_rdy = 1'b0;
      if (extra_go && !went && sent_q.size() - base == 40) begin
        go = 1'b1;
        went = 1'b1;
      end else go = 1'b0;
      if (rst50 && sent_q.size() - base == 50) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs({tag, "_midrst"});
        return;
      end
      @(negedge clk);
      k++;
    end
    rx_rdy = 1'b0;
    go = 1'b0;
    n = sent_q.size() - base;
    check({tag, "_byte_count"}, n, 98);
    check({tag, "_no_early_done"}, done_q.size() - d0, 0);
    for (int b = 0; b < 98 && b < n; b++)
      check({tag, "_byte"}, {24'd0, sent_q[base + b]}, {24'd0, exp_byte(b)});
    for (int i = sbase + 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] < min_gap) min_gap = start_q[i] - start_q[i-1];
    check({tag, "_start_gap_ge11"}, min_gap >= 11, 1);
    check({tag, "_no_start_while_busy"}, bad_start, 0);
    if (do_reply) begin
      repeat (20) @(negedge clk);
      rx_rdy = 1'b1;
      rx_data = reply;
      @(negedge clk);
      rx_rdy = 1'b0;
      exp_err = !(reply >= "0" && reply <= "9");
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_drop"}, busy, 0);
      check({tag, "_digit"}, digit, reply % 16);
      check({tag, "_resp_err"}, resp_err, exp_err);
      check({tag, "_timeout"}, timeout, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    int d0;
    int k;
    logic [7:0] r;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    for (int n = 0; n < 784; n++) pix[n] = (n % 2) == 1;
    rand_len = 1'b0;
    busy_len = 10;
    run_txn("checker", 8'h37, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 784; n++) pix[n] = (n == 783);
    rand_len = 1'b1;
    run_txn("pix783", 8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
    check("max_addr_le_783", max_addr <= 783, 1);

    for (int n = 0; n < 784; n++) pix[n] = 1'($urandom);
    run_txn("rst50", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 784; n++) pix[n] = 1'($urandom);
      r = ($urandom_range(0, 1) == 0) ? 8'(8'h30 + $urandom_range(0, 9)) : 8'($urandom);
      run_txn("random", r, 1'b1, 1'b1, (t % 2) == 0, 1'b0);
    end

    for (int n = 0; n < 784; n++) pix[n] = 1'($urandom);
    rand_len = 1'b0;
    busy_len = 10;
    d0 = done_q.size();
    run_txn("noreply", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SNN_HOST_TIMEOUT_EN
    k = 0;
    while (done_q.size() == d0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("tmo_done_seen", done_q.size() - d0, 1);
    if (done_q.size() > d0)
      check("tmo_latency", done_q[d0] - start_q[start_q.size()-1], busy_len + 102);
    check("tmo_flag", timeout, 1);
    check("tmo_digit", digit, 4'hF);
    check("tmo_resp_err", resp_err, 0);
    check("tmo_idle", busy, 0);
`else
    k = 0;
    repeat (10000) @(negedge clk);
    check("noreply_no_done", done_q.size() - d0, 0);
    check("noreply_still_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("final_rst");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/snn_img_sender.md
# snn_img_sender

Host-side initiator for the SNN digit-classification link. Reads a 784-pixel, 1-bit-per-pixel image from a synchronous image memory, packs it LSB-first into 98 bytes, and sends them through a `uart_tx` instance. It then waits for the one-byte ASCII digit reply on a `uart_rx` instance. It sits in the test-host FPGA and drives the board-level classifier over the serial link.

## Interface
- `NUM_BYTES`, 98: bytes per image. Pixels = 8*NUM_BYTES.
- `TIMEOUT_CYCLES`, 5_000_000: response-wait limit in clk cycles (100 ms at 50 MHz). Used only with the macro below.
- `clk` in 1: 50 MHz system clock. All logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `go` in 1: start pulse. Sampled only in IDLE.
- `img_addr` out 10: pixel address to the image memory.
- `img_q` in 1: pixel data. Valid one cycle after `img_addr`.
- `tx_start` out 1: one-cycle request to `uart_tx`.
- `tx_data` out 8: byte to send. Held stable from `tx_start` until the next `tx_start`.
- `tx_rdy` in 1: `uart_tx` idle. Drops the cycle after `tx_start` and returns high after the stop bit.
- `rx_rdy` in 1: one-cycle strobe from `uart_rx`.
- `rx_data` in 8: received byte. Valid while `rx_rdy` is high.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a transaction.
- `digit` out 4: last classified digit. Held until the next `done`.
- `resp_err` out 1: last reply was malformed. Updated with `done`.
- `timeout` out 1: last transaction timed out. Updated with `done`.

## Operation
- States: IDLE, FETCH, SEND, TXW, RESP.
- IDLE:
  - Byte counter `bcnt` (7b) = 0, bit counter `pcnt` (4b) = 0.
  - `go`=1 -> FETCH.
- FETCH:
  - Drive `img_addr` = 8*`bcnt` + `pcnt[2:0]` for `pcnt` = 0..7.
  - Each cycle with `pcnt` ≥ 1: `shreg <= {img_q, shreg[7:1]}`.
  - After 9 cycles (`pcnt`=8 sampled), `tx_data <= shreg` -> SEND. Pixel 8k+i lands in bit i of byte k.
- SEND: when `tx_rdy`=1, assert `tx_start` for one cycle -> TXW. Otherwise stay.
- TXW:
  - Stay for at least one cycle, then wait for `tx_rdy`=1.
  - If `bcnt` = NUM_BYTES-1 -> RESP. Otherwise `bcnt`++, `pcnt`=0 -> FETCH.
- RESP:
  - On the first `rx_rdy`: `digit <= rx_data[3:0]`.
  - `resp_err <= (rx_data[7:4] != 4'h3) || (rx_data[3:0] > 9)`.
  - `timeout <= 0`, pulse `done` -> IDLE.
- `rx_rdy` outside RESP is ignored. The byte is not captured and no error is flagged.
- `go` while `busy` is ignored. No queuing.
- Widths:
  - `img_addr` max = 8*98-1 = 783, fits 10b.
  - `bcnt` wraps only through IDLE clear, never by overflow.

## Timing
- Reset values: `img_addr`=0, `tx_start`=0, `tx_data`=0, `busy`=0, `done`=0, `digit`=0, `resp_err`=0, `timeout`=0. State = IDLE. Counters = 0.
- `rst` mid-transaction: the next cycle is IDLE with all outputs at reset values. A byte already in `uart_tx` finishes on the line. Software must resync the far end by resetting it.
- `go` at cycle 0 -> `busy`=1 at cycle 1, first `img_addr` at cycle 1.
- Per byte: 9 FETCH cycles, then 1 SEND cycle minimum, then TXW until `tx_rdy`.
- `tx_start` never asserts while `tx_rdy`=0. Back-to-back `tx_start` pulses are at least 11 cycles apart.
- `done` is asserted the cycle after the accepted `rx_rdy`. `busy` drops in the same cycle as `done`.
- `rx_rdy` coinciding with a timeout expiry: the reply wins, and `timeout`=0.

## Configuration
- `SNN_HOST_TIMEOUT_EN` defined:
  - A 23-bit counter clears on entering RESP and increments each cycle in RESP.
  - When it reaches `TIMEOUT_CYCLES`-1 with no `rx_rdy`: `timeout <= 1`, `digit <= 4'hF`, `resp_err <= 0`, pulse `done` -> IDLE.
- `SNN_HOST_TIMEOUT_EN` undefined:
  - No counter. RESP waits indefinitely.
  - `timeout` is tied to 0. `TIMEOUT_CYCLES` is unused.

## Test plan
- Checkerboard image (pixel n = n[0]), `tx_rdy` model with 10-cycle busy, reply 8'h37:
  - exactly 98 `tx_start` pulses, each with `tx_data`=8'hAA;
  - then `done`, `digit`=7, `resp_err`=0.
- Image with only pixel 783 set:
  - bytes 0..96 = 8'h00, byte 97 = 8'h80;
  - `img_addr` never exceeds 783.
- Reply 8'h41:
  - `resp_err`=1, `digit`=1.
  - Extra `rx_rdy` pulses during the send phase produce no `done`.
- `go` pulsed again at byte 40: ignored, still 98 bytes total.
- `rst` at byte 50:
  - next cycle all outputs are 0 and state is IDLE;
  - a fresh `go` restarts at `img_addr`=0.
- With `SNN_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, no reply:
  - `done` 100 cycles after RESP entry, `timeout`=1, `digit`=4'hF.
- Same bench without the macro: no `done` within 10 000 cycles.
